mem_io_responder: RTL

- Memory-side responder for the multicycle CPU's load/store/fetch requests; the other end of the controller's memory access.
- Serves a 4-phase req/ack handshake, decodes the address into block-RAM or memory-mapped I/O space, and inserts BRAM read wait-states.
- Owns the I/O registers: LED output, synchronized switch input, free-running timer and scratch.
- Sits between the datapath memory port and the external BRAM/board pins.

---
 rtl/mem_io_responder_pkg.sv | 19 +
 rtl/mem_io_responder_io_timer.sv | 32 +++
 rtl/mem_io_responder.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mem_io_responder_pkg.sv
// Shared types and constants for the memory/I-O responder: FSM states and I/O register map.
package mem_io_responder_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RAM_RD = 3'd1,
      RAM_WR = 3'd2,
      IO_ACC = 3'd3,
      ACK    = 3'd4
   } state_t;

   localparam int IO_LED     = 0;
   localparam int IO_SW      = 1;
   localparam int IO_TIMER   = 2;
   localparam int IO_SCRATCH = 3;

   localparam logic [15:0] IO_BASE_DEFAULT = 16'hFF00;

endpackage

// File: rtl/mem_io_responder_io_timer.sv
// Free-running timer: prescaler divides clk by TIMER_DIV, then a 16-bit wrapping tick counter.
module io_timer #(
   parameter int TIMER_DIV = 50000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   output logic [15:0] count
);

   localparam int PRE_W = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TIMER_DIV - 1);

   logic [PRE_W-1:0] pre_reg;
   logic [15:0]      count_reg;

   // A clear on the same edge as a tick takes priority.
   always_ff @(posedge clk) begin
      if (!reset || clear) begin
         pre_reg   <= '0;
         count_reg <= '0;
      end else if (pre_reg == PRE_MAX) begin
         pre_reg   <= '0;
         count_reg <= count_reg + 16'd1;
      end else begin
         pre_reg   <= pre_reg + 1'b1;
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/mem_io_responder.sv
// Memory-side responder: req/ack handshake, RAM vs I/O decode, BRAM read wait-states, I/O registers.
module mem_io_responder
   import mem_io_responder_pkg::*;
#(
   parameter int               ADDR_W    = 16,
   parameter int               DATA_W    = 16,
   parameter logic [ADDR_W-1:0] IO_BASE  = ADDR_W'(IO_BASE_DEFAULT),
   parameter int               RD_LAT    = 1,
   parameter int               TIMER_DIV = 50000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              ack,
   output logic [DATA_W-1:0] rdata,
   output logic              bram_en,
   output logic              bram_we,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [DATA_W-1:0] bram_wdata,
   input  logic [DATA_W-1:0] bram_rdata,
   input  logic [9:0]        sw,
   output logic [9:0]        led,
   output logic              io_err
);

   localparam int WAIT_W = 3;
   // RAM_RD spans one address cycle plus RD_LAT wait-states before the capture edge.
   localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(RD_LAT);

   state_t              state_reg, state_next;
   logic [ADDR_W-1:0]   addr_reg;
   logic                we_reg;
   logic [DATA_W-1:0]   wdata_reg;
   logic [WAIT_W-1:0]   wait_reg;
   logic [DATA_W-1:0]   rdata_reg;
   logic [9:0]          led_reg;
   logic [DATA_W-1:0]   scratch_reg;
   logic                io_err_reg;
   logic [9:0]          sw_meta_reg, sw_sync_reg;
   logic [15:0]         timer_count;
   logic                timer_clear;
   logic [ADDR_W-1:0]   io_offset;
   logic [DATA_W-1:0]   io_rd_data;
   logic                io_unmapped;

   assign io_offset   = addr_reg - IO_BASE;
   assign timer_clear = (state_reg == IO_ACC) && we_reg && (io_offset == ADDR_W'(IO_TIMER));

   io_timer #(.TIMER_DIV(TIMER_DIV)) u_timer (
      .clk   (clk),
      .reset (reset),
      .clear (timer_clear),
      .count (timer_count)
   );

   always_comb begin
      io_rd_data  = '0;
      io_unmapped = 1'b0;
      case (io_offset)
         ADDR_W'(IO_LED):     io_rd_data = DATA_W'(led_reg);
         ADDR_W'(IO_SW):      io_rd_data = DATA_W'(sw_sync_reg);
         ADDR_W'(IO_TIMER):   io_rd_data = DATA_W'(timer_count);
         ADDR_W'(IO_SCRATCH): io_rd_data = scratch_reg;
         default:             io_unmapped = 1'b1;
      endcase
   end

   always_comb begin
      state_next = state_reg;
      ack        = 1'b0;
      bram_en    = 1'b0;
      bram_we    = 1'b0;
      bram_addr  = '0;
      bram_wdata = '0;
      case (state_reg)
         IDLE: begin
            if (req)
               state_next = (addr >= IO_BASE) ? IO_ACC : (we ? RAM_WR : RAM_RD);
         end
         RAM_WR: begin
            bram_en    = 1'b1;
            bram_we    = 1'b1;
            bram_addr  = addr_reg;
            bram_wdata = wdata_reg;
            state_next = ACK;
         end
         RAM_RD: begin
            bram_en   = 1'b1;
            bram_addr = addr_reg;
            if (wait_reg == '0)
               state_next = ACK;
         end
         IO_ACC: state_next = ACK;
         ACK: begin
            ack = 1'b1;
            if (!req)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg   <= IDLE;
         addr_reg    <= '0;
         we_reg      <= 1'b0;
         wdata_reg   <= '0;
         wait_reg    <= '0;
         rdata_reg   <= '0;
         led_reg     <= '0;
         scratch_reg <= '0;
         io_err_reg  <= 1'b0;
         sw_meta_reg <= '0;
         sw_sync_reg <= '0;
      end else begin
         state_reg   <= state_next;
         sw_meta_reg <= sw;
         sw_sync_reg <= sw_meta_reg;
         case (state_reg)
            IDLE: begin
               if (req) begin
                  addr_reg  <= addr;
                  we_reg    <= we;
                  wdata_reg <= wdata;
                  wait_reg  <= WAIT_INIT;
               end
            end
            RAM_RD: begin
               if (wait_reg == '0)
                  rdata_reg <= bram_rdata;
               else
                  wait_reg <= wait_reg - 1'b1;
            end
            IO_ACC: begin
               if (io_unmapped)
                  io_err_reg <= 1'b1;
               if (we_reg) begin
                  if (io_offset == ADDR_W'(IO_LED))
                     led_reg <= wdata_reg[9:0];
                  if (io_offset == ADDR_W'(IO_SCRATCH))
                     scratch_reg <= wdata_reg;
               end else begin
                  rdata_reg <= io_rd_data;
               end
            end
            default: ;
         endcase
      end
   end

   assign rdata  = rdata_reg;
   assign led    = led_reg;
   assign io_err = io_err_reg;

endmodule
